// File: rtl/async_fifo_rd_port.sv
// async_fifo_rd_port: read-side endpoint of a clock-domain-crossing FIFO.
// Optional `ASYNC_FIFO_RD_SYNC3_EN selects a 3-flop write-pointer synchroniser.
module async_fifo_rd_port #(
  parameter int fifo_data_size = 8,
  parameter int fifo_ptr_size  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [fifo_ptr_size:0]    wr_ptr_gray,
  output logic [fifo_ptr_size:0]    rd_ptr_gray,
  output logic                      mem_rd_en,
  output logic [fifo_ptr_size-1:0]  mem_rd_addr,
  input  logic [fifo_data_size-1:0] mem_rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [fifo_data_size-1:0] out_data,
  output logic [fifo_ptr_size:0]    fifo_fill
);

  localparam int PW = fifo_ptr_size + 1;
  localparam int DW = fifo_data_size;

  logic [PW-1:0] r_sync1;
  logic [PW-1:0] r_sync2;
  logic [PW-1:0] w_sync_last;
  logic [PW-1:0] w_wr_ptr_bin;

  logic [PW-1:0] r_rd_counter;
  logic [PW-1:0] r_rd_ptr_gray;
  logic [PW-1:0] r_fifo_fill;
  logic [PW-1:0] w_rd_cnt_nxt;
  logic [PW-1:0] w_rd_gray_nxt;

  logic          r_inflight;
  logic [1:0]    r_buf_cnt;
  logic [DW-1:0] r_head;
  logic [DW-1:0] r_skid;

  logic          w_mem_empty;
  logic          w_pop;
  logic [1:0]    w_occ;
  logic          w_issue;

`ifdef ASYNC_FIFO_RD_SYNC3_EN
  logic [PW-1:0] r_sync3;

  // Three-stage synchroniser for the foreign Gray write pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= wr_ptr_gray;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_sync_last = r_sync3;
`else
  // Two-stage synchroniser for the foreign Gray write pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= wr_ptr_gray;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync_last = r_sync2;
`endif

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  for (genvar gi = 0; gi < PW; gi++) begin : g_g2b
    assign w_wr_ptr_bin[gi] = ^w_sync_last[PW-1:gi];
  end

  assign w_mem_empty = (r_rd_counter == w_wr_ptr_bin);
  assign w_pop       = (r_buf_cnt != 2'd0) && out_ready;

  // Occupancy the output stage will have after this cycle's pop
  assign w_occ   = r_buf_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue = !w_mem_empty && (w_occ < 2'd2);

  assign w_rd_cnt_nxt  = r_rd_counter + {{(PW-1){1'b0}}, w_issue};
  assign w_rd_gray_nxt = w_rd_cnt_nxt ^ (w_rd_cnt_nxt >> 1);

  // Read pointer, published Gray pointer, fill level and inflight flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_counter  <= '0;
      r_rd_ptr_gray <= '0;
      r_fifo_fill   <= '0;
      r_inflight    <= 1'b0;
    end else begin
      r_rd_counter  <= w_rd_cnt_nxt;
      r_rd_ptr_gray <= w_rd_gray_nxt;
      r_fifo_fill   <= w_wr_ptr_bin - r_rd_counter;
      r_inflight    <= w_issue;
    end
  end

  // Two-entry output stage; skid drains into head so order is preserved
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_cnt <= 2'd0;
      r_head    <= '0;
      r_skid    <= '0;
    end else if (w_pop) begin
      if (r_buf_cnt == 2'd2) begin
        r_head <= r_skid;
        if (r_inflight) begin
          r_skid <= mem_rd_data;
        end else begin
          r_buf_cnt <= 2'd1;
        end
      end else begin
        if (r_inflight) begin
          r_head <= mem_rd_data;
        end else begin
          r_buf_cnt <= 2'd0;
        end
      end
    end else if (r_inflight) begin
      if (r_buf_cnt == 2'd0) begin
        r_head    <= mem_rd_data;
        r_buf_cnt <= 2'd1;
      end else begin
        r_skid    <= mem_rd_data;
        r_buf_cnt <= 2'd2;
      end
    end
  end

  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = r_rd_counter[fifo_ptr_size-1:0];
  assign rd_ptr_gray = r_rd_ptr_gray;
  assign fifo_fill   = r_fifo_fill;
  assign out_valid   = (r_buf_cnt != 2'd0);
  assign out_data    = r_head;

endmodule

// File: tb/tb_async_fifo_rd_port.sv
// tb_async_fifo_rd_port: directed bench for async_fifo_rd_port at depth 16.
// Honours `ASYNC_FIFO_RD_SYNC3_EN for the synchroniser latency.
module tb_async_fifo_rd_port;

`ifdef ASYNC_FIFO_RD_SYNC3_EN
  localparam int SL = 1;
`else
  localparam int SL = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] wr_ptr_gray;
  logic [4:0] rd_ptr_gray;
  logic       mem_rd_en;
  logic [3:0] mem_rd_addr;
  logic [7:0] mem_rd_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] fifo_fill;

  logic [7:0] mem [16];
  logic [7:0] ram_q;

  int         n_vec = 0;
  int         n_err = 0;
  int         n_iss = 0;
  logic [7:0] rx [$];
  logic [4:0] prev_g = 5'd0;
  logic       saw_wrap = 1'b0;

  async_fifo_rd_port #(
    .fifo_data_size(8),
    .fifo_ptr_size (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_ptr_gray(wr_ptr_gray),
    .rd_ptr_gray(rd_ptr_gray),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_fill  (fifo_fill)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) ram_q <= mem[mem_rd_addr];
  end
  assign mem_rd_data = ram_q;

  always @(posedge clk) begin
    if (mem_rd_en) n_iss <= n_iss + 1;
    if (!reset && out_valid && out_ready) rx.push_back(out_data);
    if (prev_g == 5'd16 && rd_ptr_gray == 5'd0) saw_wrap <= 1'b1;
    prev_g <= rd_ptr_gray;
  end

  function automatic logic [4:0] gray5(input logic [4:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 4; i > 0; i--) b[i-1] = b[i] ^ g[i-1];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [4:0] wr5;
    logic [4:0] d;
    int         base;
    int         sent;
    int         cyc;
    int         n0;
    int         got_n;
    logic [4:0] maxfill;

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'hA0;
    mem[1] = 8'hA1;
    mem[2] = 8'hA2;
    reset       = 1'b1;
    wr_ptr_gray = 5'd0;
    out_ready   = 1'b0;
    wr5         = 5'd0;

    // reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {out_valid, mem_rd_en, rd_ptr_gray, fifo_fill}, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", {out_valid, mem_rd_en, rd_ptr_gray, fifo_fill}, 0);
    end

    // empty-to-data latency, three words
    out_ready   = 1'b1;
    wr5         = 5'd3;
    wr_ptr_gray = gray5(wr5);
    @(posedge clk);
    repeat (SL) @(posedge clk);
    @(negedge clk);
    chk("lat_e0_rden", mem_rd_en, 0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("lat_rden", mem_rd_en, (k <= 3) ? 1 : 0);
      if (k <= 3) chk("lat_addr", mem_rd_addr, k - 1);
      chk("lat_valid", out_valid, (k >= 3 && k <= 5) ? 1 : 0);
      if (k >= 3 && k <= 5) chk("lat_data", out_data, 8'hA0 + k - 3);
    end
    chk("lat_rdgray", rd_ptr_gray, 5'd2);
    chk("lat_fill", fifo_fill, 5'd0);

    // backpressure, five words
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) mem[3+i] = 8'hB0 + 8'(i);
    n0          = n_iss;
    wr5         = 5'd8;
    wr_ptr_gray = gray5(wr5);
    repeat (10) @(negedge clk);
    chk("bp_issues", n_iss - n0, 2);
    chk("bp_valid", out_valid, 1);
    chk("bp_head", out_data, 8'hB0);
    chk("bp_fill", fifo_fill, 5'd3);
    repeat (3) @(negedge clk);
    chk("bp_hold", out_data, 8'hB0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_run", out_valid, 1);
      chk("bp_data_run", out_data, 8'hB0 + i);
      @(negedge clk);
    end
    chk("bp_drained", out_valid, 0);

    // 40 words through depth 16 with random backpressure
    base    = rx.size();
    sent    = 0;
    cyc     = 0;
    maxfill = 5'd0;
    while ((rx.size() - base) < 40 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (fifo_fill > maxfill) maxfill = fifo_fill;
      out_ready = 1'($urandom_range(0, 1));
      d = wr5 - g2b(rd_ptr_gray);
      if (sent < 40 && d < 5'd16) begin
        mem[wr5[3:0]] = 8'h40 + 8'(sent);
        wr5           = wr5 + 5'd1;
        wr_ptr_gray   = gray5(wr5);
        sent++;
      end
    end
    got_n = rx.size() - base;
    chk("wrap_count", got_n, 40);
    for (int i = 0; i < 40 && i < got_n; i++)
      chk("wrap_data", rx[base+i], 8'h40 + i);
    chk("wrap_seen", saw_wrap, 1);
    chk("wrap_maxfill_le16", (maxfill <= 5'd16) ? 1 : 0, 1);
    chk("wrap_rdgray", rd_ptr_gray, 5'd24);

    // reset with two words buffered
    out_ready   = 1'b0;
    n0          = n_iss;
    wr5         = 5'd19;
    wr_ptr_gray = gray5(wr5);
    repeat (8) @(negedge clk);
    chk("rst2_issues", n_iss - n0, 2);
    chk("rst2_valid", out_valid, 1);
    chk("rst2_head", out_data, 8'h58);
    reset       = 1'b1;
    wr5         = 5'd0;
    wr_ptr_gray = 5'd0;
    @(negedge clk);
    chk("rst2_after", {out_valid, mem_rd_en, rd_ptr_gray, fifo_fill}, 0);
    reset = 1'b0;

    // reset with a read in flight
    wr5         = 5'd3;
    wr_ptr_gray = gray5(wr5);
    cyc         = 0;
    @(negedge clk);
    while (!out_valid && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    chk("rsti_valid", out_valid, 1);
    reset       = 1'b1;
    wr5         = 5'd0;
    wr_ptr_gray = 5'd0;
    @(negedge clk);
    chk("rsti_after", {out_valid, rd_ptr_gray, fifo_fill}, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rsti_quiet", out_valid, 0);
    end

    // full memory
    wr5         = 5'd16;
    wr_ptr_gray = gray5(wr5);
    repeat (3 + SL) @(posedge clk);
    @(negedge clk);
    chk("full_fill16", fifo_fill, 5'd16);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("full_fill14", fifo_fill, 5'd14);
    repeat (4) @(negedge clk);
    chk("full_fill14_hold", fifo_fill, 5'd14);
    chk("full_rdgray", rd_ptr_gray, 5'd3);
    chk("full_head", out_data, 8'h58);
    chk("full_rden", mem_rd_en, 0);
    base      = rx.size();
    out_ready = 1'b1;
    cyc       = 0;
    while ((rx.size() - base) < 16 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    got_n = rx.size() - base;
    chk("full_count", got_n, 16);
    for (int i = 0; i < 16 && i < got_n; i++)
      chk("full_data", rx[base+i], 8'h58 + i);
    @(negedge clk);
    chk("full_end_fill", fifo_fill, 5'd0);
    chk("full_end_rdgray", rd_ptr_gray, 5'd24);
    chk("full_end_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
